// File: rtl/ahfp_pkg.sv
// Shared types for the AHFP drain block: data word width, word typedef and pointer-width helper.
package ahfp_pkg;

    localparam int AHFP_WIDTH = 32;

    typedef logic [AHFP_WIDTH-1:0] ahfp_word_t;

    function automatic int ahfp_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ahfp_drain_fifo.sv
// First-word fall-through FIFO for the drain block; any DEPTH >= 2, pointers wrap explicitly.
// With AHFP_DRAIN_CHECK_EN defined, a write into a full FIFO without a same-cycle pop is dropped and flagged on ovf_o.
module ahfp_drain_fifo
    import ahfp_pkg::*;
#(
    parameter  int DEPTH = 12,
    localparam int PW    = ahfp_ptr_w(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  ahfp_word_t    wr_data_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output ahfp_word_t    rd_data_o,
    output logic [CW-1:0] count_o
`ifdef AHFP_DRAIN_CHECK_EN
    ,
    output logic          ovf_o
`endif
);

    ahfp_word_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;
    logic          wr_acc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop = (count_q != '0) && rd_ready_i;

`ifdef AHFP_DRAIN_CHECK_EN
    logic full;
    assign full   = (count_q == CW'(DEPTH));
    assign wr_acc = wr_en_i && !(full && !pop);
    assign ovf_o  = wr_en_i && full && !pop;
`else
    assign wr_acc = wr_en_i;
`endif

    always_comb begin
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left unreset; the output mask hides stale words.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/ahfp_pipeline_drain.sv
// Drain end of the AHFP stall-free pipeline: credit-gated issue plus a result FIFO. Optional checks: AHFP_DRAIN_CHECK_EN.
// out_valid/out_ready: a word transfers on any rising edge where both are high; out_data is stable while out_valid waits.
module ahfp_pipeline_drain
    import ahfp_pkg::*;
#(
    parameter  int N     = 10,
    parameter  int DEPTH = 12,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ok,
    input  logic       res_valid,
    input  ahfp_word_t res_data,
    output logic       out_valid,
    input  logic       out_ready,
    output ahfp_word_t out_data,
    output logic       err
);

    if (N < 1 || DEPTH < 2) begin : g_bad_cfg
        $error("ahfp_pipeline_drain: N must be >= 1 and DEPTH >= 2");
    end

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          issue_cnt;
    logic          res_dec;
    logic          wr_en;

    // Every slot is either occupied or reserved by an operand still in the pipeline.
    assign credit_used = {1'b0, count} + {1'b0, inflight_q};
    assign issue_ok    = credit_used < (CW + 1)'(DEPTH);

`ifdef AHFP_DRAIN_CHECK_EN
    logic err_q, err_d;
    logic ovf;

    assign issue_cnt = issue_valid && issue_ok;
    assign res_dec   = res_valid && (inflight_q != '0);
    assign wr_en     = res_dec;
    assign err_d     = err_q
                     || (issue_valid && !issue_ok)
                     || (res_valid && (inflight_q == '0))
                     || ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign issue_cnt = issue_valid;
    assign res_dec   = res_valid;
    assign wr_en     = res_valid;
    assign err       = 1'b0;
`endif

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_cnt, res_dec})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    ahfp_drain_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (res_data),
        .rd_ready_i(out_ready),
        .rd_valid_o(out_valid),
        .rd_data_o (out_data),
        .count_o   (count)
`ifdef AHFP_DRAIN_CHECK_EN
        ,
        .ovf_o     (ovf)
`endif
    );

endmodule

// File: tb/tb_ahfp_pipeline_drain.sv
// Bench for ahfp_pipeline_drain: upstream pipeline model, random/directed drivers, queue scoreboard.
// Expected order is issue order; credit check uses issued-minus-popped arithmetic.
module tb_ahfp_pipeline_drain;
    import ahfp_pkg::*;

    localparam int N     = 10;
    localparam int DEPTH = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_ok;
    logic       res_valid;
    ahfp_word_t res_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    ahfp_word_t out_data;
    logic       err;

    ahfp_word_t issue_data = '0;
    logic       inj_valid  = 1'b0;
    ahfp_word_t inj_data   = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_iss = 0;
    int n_pop = 0;

    logic [31:0] exp_q[$];
    int          exp_t_q[$];
    int          out_cycles[$];

    ahfp_pipeline_drain #(
        .N    (N),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ok   (issue_ok),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err        (err)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream fixed-latency pipeline, reset by the same rst
    logic       pv [N];
    ahfp_word_t pd [N];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= issue_valid;
            pd[0] <= issue_data;
            for (int i = 1; i < N; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign res_valid = pv[N-1] | inj_valid;
    assign res_data  = pv[N-1] ? pd[N-1] : inj_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: one cycle of stimulus; upstream only issues when credit is available
    task automatic drive(input bit want, input bit ready, input bit fix = 1'b0, input logic [31:0] val = 32'h0);
        @(posedge clk);
        #1;
        issue_valid = want && issue_ok;
        out_ready   = ready;
        if (issue_valid) begin
            issue_data = fix ? val : $urandom;
            exp_q.push_back(issue_data);
            exp_t_q.push_back(cyc);
        end else begin
            issue_data = '0;
        end
    endtask

    task automatic drain(input string name, input bit toggle);
        int  budget = 300;
        bit  r = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            drive(1'b0, r);
            if (toggle) r = ~r;
            budget--;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor / scoreboard at negedge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("issue_ok_credit", {31'b0, issue_ok}, {31'b0, (n_iss - n_pop) < DEPTH});
`ifndef AHFP_DRAIN_CHECK_EN
            chk("err_tied_low", {31'b0, err}, 32'h0);
`endif
            if (out_valid) begin
                out_cycles.push_back(cyc);
                if (out_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL out_unexpected: got 0x%08h with no expected word (cycle %0d)", out_data, cyc);
                    end else begin
                        logic [31:0] e;
                        int          t;
                        e = exp_q.pop_front();
                        t = exp_t_q.pop_front();
                        if (out_data !== e) begin
                            n_err++;
                            $display("FAIL out_data: got 0x%08h expected 0x%08h (cycle %0d)", out_data, e, cyc);
                        end
                        chk("latency_min", {31'b0, cyc >= t + N + 1}, 32'h1);
                    end
                end
            end else begin
                chk("out_data_masked", out_data, 32'h0);
            end
            if (issue_valid) n_iss++;
            if (out_valid && out_ready) n_pop++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        int acc;
        int first_low;
        int low_seen;
        int gaps;
        int issued;
        int budget;
        bit tog;

        // Reset values, asserted before any clock edge
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_issue_ok", {31'b0, issue_ok}, 32'h1);
        chk("rst_err", {31'b0, err}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op: out_valid only in cycle issue+N+1
        out_cycles.delete();
        drive(1'b1, 1'b1, 1'b1, 32'h3F80_0000);
        s = cyc;
        repeat (N + 4) drive(1'b0, 1'b1);
        chk("single_out_count", out_cycles.size(), 1);
        if (out_cycles.size() >= 1) chk("single_out_cycle", out_cycles[0], s + N + 1);
        chk("single_drained", exp_q.size(), 0);

        // Backpressure: exactly DEPTH credits, then refill after first pop
        acc = 0;
        first_low = -1;
        s = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b0);
            if (i == 0) s = cyc;
            if (issue_valid) acc++;
            if (!issue_ok && first_low < 0) first_low = cyc - s;
        end
        chk("bp_accepted", acc, DEPTH);
        chk("bp_ok_low_cycle", first_low, DEPTH);
        chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
        drive(1'b0, 1'b1);
        chk("bp_ok_at_first_pop", {31'b0, issue_ok}, 32'h0);
        drive(1'b0, 1'b1);
        chk("bp_ok_reassert", {31'b0, issue_ok}, 32'h1);
        drain("bp_drained", 1'b0);

        // Throughput: 100 continuous issues, 100 consecutive outputs
        out_cycles.delete();
        low_seen = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b1);
            if (i == 0) s = cyc;
            if (!issue_valid) low_seen++;
        end
        repeat (N + 5) drive(1'b0, 1'b1);
        chk("tp_ok_never_low", low_seen, 0);
        chk("tp_out_count", out_cycles.size(), 100);
        if (out_cycles.size() >= 1) chk("tp_first_out", out_cycles[0], s + N + 1);
        gaps = 0;
        for (int i = 1; i < out_cycles.size(); i++) begin
            if (out_cycles[i] != out_cycles[i-1] + 1) gaps++;
        end
        chk("tp_consecutive", gaps, 0);

        // Wrap with toggling out_ready
        issued = 0;
        budget = 200;
        tog = 1'b1;
        while (issued < 30 && budget > 0) begin
            drive(1'b1, tog);
            tog = ~tog;
            if (issue_valid) issued++;
            budget--;
        end
        chk("wrap_issued", issued, 30);
        drain("wrap_drained", 1'b1);
        drive(1'b0, 1'b0);
        chk("wrap_empty", {31'b0, out_valid}, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 2) != 0)));
        end
        drain("rand_drained", 1'b0);

        // Asynchronous reset mid-stream with count = 5 and inflight = 3
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0);
        repeat (7) drive(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_issue_ok", {31'b0, issue_ok}, 32'h1);
        chk("mid_rst_err", {31'b0, err}, 32'h0);
        exp_q.delete();
        exp_t_q.delete();
        n_iss = 0;
        n_pop = 0;
        issue_valid = 1'b0;
        issue_data  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_cycles.delete();
        repeat (N + 5) drive(1'b0, 1'b1);
        chk("rst_no_stale", out_cycles.size(), 0);
        drive(1'b1, 1'b1);
        repeat (N + 4) drive(1'b0, 1'b1);
        chk("rst_fresh_op", exp_q.size(), 0);

`ifdef AHFP_DRAIN_CHECK_EN
        // Result with nothing in flight: dropped, err sticky until rst
        @(posedge clk);
        #1;
        inj_valid = 1'b1;
        inj_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        chk("chk_err_set", {31'b0, err}, 32'h1);
        chk("chk_dropped", {31'b0, out_valid}, 32'h0);
        repeat (5) drive(1'b0, 1'b1);
        chk("chk_err_hold", {31'b0, err}, 32'h1);
        chk("chk_still_empty", {31'b0, out_valid}, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("chk_err_cleared", {31'b0, err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`else
        drive(1'b0, 1'b1);
        chk("nochk_err_low", {31'b0, err}, 32'h0);
`endif

        repeat (3) drive(1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
